// File: rtl/rr_grant_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot grant and a hold timeout.
// Every grant ends in IDLE, so consecutive grants are always separated by one idle cycle.
module rr_grant_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       grant_q, grant_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [2:0]       win_idx;
  logic [2:0]       cand;

  // Rotating priority scan: ptr, ptr+1, ... wrapping mod 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          grant_d = 8'b1 << win_idx;
          cnt_d   = CNT_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req[idx_q] || (HOLD_MAX != 0 && cnt_q == HOLD_C)) begin
          // Release wins over timeout when both happen on the same edge.
          timeout_d = req[idx_q];
          grant_d   = 8'h00;
          ptr_d     = idx_q + 3'd1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      grant_q   <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == BUSY);
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: one instance with HOLD_MAX=16, one with HOLD_MAX=4.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.HOLD_MAX(16), .CNT_W(5)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a),
    .grant(gnt_a), .grant_idx(idx_a), .grant_valid(vld_a), .timeout(to_a)
  );

  rr_grant_arbiter #(.HOLD_MAX(4), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b),
    .grant(gnt_b), .grant_idx(idx_b), .grant_valid(vld_b), .timeout(to_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
  endtask

  // Expected state of instance A, packed as {valid, idx, grant, timeout}.
  task automatic chk_a(input string tag, input logic v, input logic [2:0] i, input logic t);
    logic [7:0] g;
    g = v ? (8'h01 << i) : 8'h00;
    chk({tag, "_a"}, {19'd0, vld_a, idx_a, gnt_a, to_a}, {19'd0, v, i, g, t});
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [2:0] i, input logic t);
    logic [7:0] g;
    g = v ? (8'h01 << i) : 8'h00;
    chk({tag, "_b"}, {19'd0, vld_b, idx_b, gnt_b, to_b}, {19'd0, v, i, g, t});
  endtask

  initial begin
    rst   = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    #2;

    // Reset state and idle behaviour.
    rst = 1'b1;
    #1;
    chk_a("rst", 1'b0, 3'd0, 1'b0);
    chk_b("rst", 1'b0, 3'd0, 1'b0);
    #2 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk_a("idle", 1'b0, 3'd0, 1'b0);
    end

    // Single requester 3 held for 5 grant cycles, then dropped.
    req_a = 8'h08;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_a("single_hold", 1'b1, 3'd3, 1'b0);
    end
    req_a = 8'h00;
    step();
    chk_a("single_rel", 1'b0, 3'd3, 1'b0);
    // Scan now starts at 4, so 4 beats 3.
    req_a = 8'h18;
    step();
    chk_a("single_ptr4", 1'b1, 3'd4, 1'b0);

    // Asynchronous reset while granted clears before the next edge.
    #2 rst = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    req_a = 8'h00;
    step();

    // Round-robin fairness under req=FF with each owner pulsing its bit low.
    req_a = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_a("rr_gnt", 1'b1, 3'(k % 8), 1'b0);
      step();
      chk_a("rr_hold", 1'b1, 3'(k % 8), 1'b0);
      req_a = 8'hFF & ~(8'h01 << (k % 8));
      step();
      chk_a("rr_gap", 1'b0, 3'(k % 8), 1'b0);
      req_a = 8'hFF;
    end

    // Priority wrap: serve 5, then 6 wins over 0, then 0.
    req_a = 8'h00;
    do_reset();
    req_a = 8'h20;
    step();
    chk_a("wrap_5", 1'b1, 3'd5, 1'b0);
    req_a = 8'h00;
    step();
    req_a = 8'h41;
    step();
    chk_a("wrap_6", 1'b1, 3'd6, 1'b0);
    req_a = 8'h01;
    step();
    chk_a("wrap_gap", 1'b0, 3'd6, 1'b0);
    step();
    chk_a("wrap_0", 1'b1, 3'd0, 1'b0);
    req_a = 8'h00;

    // Timeout with HOLD_MAX=4 and req=05: 0 x4, pulse, 2 x4, pulse, 0.
    do_reset();
    req_b = 8'h05;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk_b("to_hold", 1'b1, (r == 0) ? 3'd0 : 3'd2, 1'b0);
      end
      step();
      chk_b("to_pulse", 1'b0, (r == 0) ? 3'd0 : 3'd2, 1'b1);
    end
    step();
    chk_b("to_back0", 1'b1, 3'd0, 1'b0);

    // Release on the same edge the count reaches HOLD_MAX: no timeout.
    req_b = 8'h00;
    do_reset();
    req_b = 8'h01;
    for (int c = 0; c < 4; c++) step();
    chk_b("coin_hold", 1'b1, 3'd0, 1'b0);
    req_b = 8'h00;
    step();
    chk_b("coin_rel", 1'b0, 3'd0, 1'b0);

    // Sole timed-out requester is re-granted after one gap cycle.
    req_b = 8'h80;
    step();
    chk_b("sole_gnt", 1'b1, 3'd7, 1'b0);
    for (int c = 0; c < 3; c++) step();
    chk_b("sole_hold", 1'b1, 3'd7, 1'b0);
    step();
    chk_b("sole_to", 1'b0, 3'd7, 1'b1);
    step();
    chk_b("sole_regnt", 1'b1, 3'd7, 1'b0);
    req_b = 8'h00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Issues a registered one-hot grant, which is the 3-to-8 decode of the winning index gated by grant_valid, plus the encoded index.
- Holds the grant until the owner drops its request or a hold timeout expires.
- Sits in front of any shared 8-way datapath; grant drives that datapath's select/enable lines directly.

Parameters:
- HOLD_MAX, default 16: maximum consecutive cycles one requester may hold the grant. 0 disables the timeout.
- CNT_W, default 5: hold counter width. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  8  request vector; bit i = requester i. Level-sensitive, held while the requester wants the resource.
- grant  output  8  registered one-hot grant; all zero when idle.
- grant_idx  output  3  index of the current owner; holds its last value when idle.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX expiry.

Behaviour:
- Reset (asserted, asynchronous): grant=8'h00, grant_idx=0, grant_valid=0, timeout=0, priority pointer ptr=0, hold counter cnt=0, state=IDLE.
- Reset asserted mid-grant clears all of the above immediately, without waiting for a clock edge.
- All outputs are registered.
- Invariant: grant == (grant_valid ? 1<<grant_idx : 0). Never more than one bit set.
- State IDLE:
  - If req==0: remain in IDLE; outputs stay idle.
  - Else: winner = first set bit of req scanning ptr, ptr+1, … 7, 0, … ptr-1 (mod 8).
  - At the same edge: grant_idx=winner, grant=one-hot(winner), grant_valid=1, cnt=1, state=BUSY.
  - Latency: req sampled at edge k is granted visibly after edge k (1 cycle).
- State BUSY, evaluated each edge with idx=grant_idx:
  - Release: req[idx]==0. Clear grant/grant_valid, ptr=idx+1 mod 8, cnt=0, state=IDLE. timeout stays 0.
  - Timeout: req[idx]==1, HOLD_MAX!=0 and cnt==HOLD_MAX. Clear grant/grant_valid, timeout=1 for exactly one cycle, ptr=idx+1 mod 8, cnt=0, state=IDLE.
  - Otherwise: hold the grant, cnt=cnt+1.
  - Result: a grant is visible for at most HOLD_MAX cycles.
- Gap cycle: every grant ends in IDLE, so there is exactly one cycle with grant_valid=0 between consecutive grants. No direct handoff.
- Request changes by non-owners during BUSY are ignored. They are only evaluated in IDLE.
- The pointer advances only on grant end, never in IDLE with no request.
- A timed-out requester that keeps requesting has lowest priority next round. It is re-granted after the gap cycle only if no other bit is set.
- The requester that just released or timed out sits at the ptr-1 position in the next scan.
- ptr wraps from 7 to 0; cnt never exceeds HOLD_MAX.
- With HOLD_MAX=0, cnt saturates at 2^CNT_W-1 rather than wrapping and does not affect behaviour.
- timeout is 0 in every cycle other than the single pulse cycle.

Test Plan:
- Reset then idle: rst pulse, req=0 for 10 cycles -> grant=0, grant_valid=0, grant_idx=0, timeout=0 throughout. Raising rst asynchronously mid-cycle while granted clears grant before the next edge.
- Single requester: req=8'h08 held 5 cycles, then dropped -> grant=8'h08, grant_idx=3 one cycle after req rises. Grant held 5 cycles, cleared one cycle after the drop; next scan then starts at 4.
- Round-robin fairness: req=8'hFF held constantly, HOLD_MAX=16, each owner's bit pulsed low for 1 cycle after 2 cycles of grant -> grant order 0,1,2,…,7,0. Each grant separated by one grant_valid=0 cycle.
- Priority wrap: ptr=6 (after serving 5), req=8'h41 -> grant_idx=6 first. After its release, grant_idx=0.
- Timeout: HOLD_MAX=4, req=8'h05 held constantly -> grant_idx=0 for exactly 4 cycles, timeout pulse 1 cycle at revocation. Gap cycle, then grant_idx=2 for 4 cycles, then 0 again.
- Release/timeout coincidence: HOLD_MAX=4, owner drops req on the same edge cnt==4 -> grant cleared, timeout stays 0. Also check sole timed-out requester req=8'h80 -> re-granted after one gap cycle.
